// File: rtl/instr_fetch_pkg.sv
// ============================================================================
// instr_fetch_pkg -- shared core constants (XLEN, NOP encoding) and PC helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package instr_fetch_pkg;

  localparam int              c_XLEN    = 32;
  localparam logic [31:0]     c_NOP     = 32'h0000_0013;
  localparam logic [31:0]     c_PC_STEP = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo -- small circular FIFO with flush and occupancy count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_PW-1:0]  rd_q, rd_d;
  logic [c_PW-1:0]  wr_q, wr_d;
  logic [c_CW-1:0]  count_q, count_d;
  logic             w_push, w_pop, w_full;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
    return (p == c_PW'(DEPTH-1)) ? '0 : p + c_PW'(1);
  endfunction

  assign w_full  = (count_q == c_CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_head  = mem_q[rd_q];
  assign o_count = count_q;

  always_comb begin
    rd_d    = w_pop  ? ptr_inc(rd_q) : rd_q;
    wr_d    = w_push ? ptr_inc(wr_q) : wr_q;
    count_d = count_q + c_CW'(w_push) - c_CW'(w_pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst && !i_flush) begin
      mem_q[wr_q] <= i_push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch -- in-order instruction fetch with bounded in-flight requests,
// response buffering and redirect flush. Revision: 1.0
// ============================================================================
`default_nettype none

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  localparam int          c_CW       = $clog2(DEPTH+1);
  localparam logic [31:0] c_RESET_PC = align_pc(RESET_PC);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     deliver_pc_q, deliver_pc_d;
  logic [c_CW-1:0] inflight_q, inflight_d;
  logic [c_CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [c_CW-1:0] w_fifo_count;
  logic            w_fifo_empty;
  logic [31:0]     w_fifo_head;
  logic [c_CW:0]   w_occupancy;
  logic            w_req_valid, w_accept, w_rsp, w_drop, w_push;
  logic            w_out_valid, w_pop;

  assign w_occupancy = {1'b0, inflight_q} + {1'b0, w_fifo_count};
  assign w_req_valid = !i_rst && !i_redirect && (w_occupancy < (c_CW+1)'(DEPTH));
  assign w_accept    = w_req_valid && i_imem_req_ready;
  // A response with nothing outstanding cannot belong to us; ignore it.
  assign w_rsp       = i_imem_rsp_valid && !i_rst && (inflight_q != '0);
  assign w_drop      = (drop_cnt_q != '0);
  assign w_push      = w_rsp && !w_drop && !i_redirect;
  assign w_out_valid = !w_fifo_empty && !i_redirect && !i_rst;
  assign w_pop       = w_out_valid && i_ready;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    deliver_pc_d = deliver_pc_q;
    inflight_d   = inflight_q + c_CW'(w_accept) - c_CW'(w_rsp);
    drop_cnt_d   = drop_cnt_q;
    if (i_redirect) begin
      fetch_pc_d   = align_pc(i_redirect_pc);
      deliver_pc_d = align_pc(i_redirect_pc);
      // Every request still outstanding after this cycle must be discarded.
      drop_cnt_d   = inflight_q - c_CW'(w_rsp);
    end else begin
      if (w_accept)         fetch_pc_d   = fetch_pc_q + c_PC_STEP;
      if (w_pop)            deliver_pc_d = deliver_pc_q + c_PC_STEP;
      if (w_rsp && w_drop)  drop_cnt_d   = drop_cnt_q - c_CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc_q   <= c_RESET_PC;
      deliver_pc_q <= c_RESET_PC;
      inflight_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      deliver_pc_q <= deliver_pc_d;
      inflight_q   <= inflight_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_XLEN)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_flush     (i_redirect),
    .i_push      (w_push),
    .i_push_data (i_imem_rsp_data),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  // Reset gating keeps outputs at reset values from the first reset cycle.
  assign o_imem_req_valid = w_req_valid;
  assign o_imem_req_addr  = i_rst ? c_RESET_PC : align_pc(fetch_pc_q);
  assign o_valid          = w_out_valid;
  assign o_instr          = (w_fifo_empty || i_rst) ? c_NOP : w_fifo_head;
  assign o_pc             = i_rst ? c_RESET_PC : deliver_pc_q;

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, maximum instructions in flight plus buffered (2..4).
REQ-003 SHALL have one clock, i_clk; reset i_rst is synchronous and active-high.
REQ-004 Ports:
 i_clk  input  1  clock
 i_rst  input  1  synchronous active-high reset
 o_imem_req_valid  output  1  fetch request valid
 i_imem_req_ready  input  1  memory accepts request
 o_imem_req_addr  output  32  word-aligned fetch address
 i_imem_rsp_valid  input  1  response valid (in order, >=1 cycle after accept, no backpressure)
 i_imem_rsp_data  input  32  fetched instruction
 i_redirect  input  1  taken branch/jump from a later stage
 i_redirect_pc  input  32  redirect target
 o_valid  output  1  instruction available to decoder
 i_ready  input  1  decoder accepts
 o_instr  output  32  instruction to decoder
 o_pc  output  32  PC of o_instr

Function
REQ-005 SHALL hold fetch_pc; a request is accepted when o_imem_req_valid && i_imem_req_ready, then fetch_pc += 4 (mod 2^32, wrap 0xFFFF_FFFC -> 0).
REQ-006 o_imem_req_addr SHALL equal {fetch_pc[31:2],2'b00} and stay stable while valid && !ready.
REQ-007 o_imem_req_valid SHALL be 1 iff !i_rst && !i_redirect && (inflight + fifo_count) < DEPTH.
REQ-008 inflight SHALL increment on accept, decrement on i_imem_rsp_valid, both same cycle = no change.
REQ-009 Responses SHALL be pushed into an internal FIFO of DEPTH entries unless drop_cnt > 0, in which case drop_cnt decrements and data is discarded.
REQ-010 o_valid SHALL be FIFO non-empty and !i_redirect; o_instr = FIFO head; when empty o_instr = 32'h0000_0013 (NOP).
REQ-011 Latency SHALL be registered: response in cycle N -> o_valid earliest cycle N+1; no combinational rsp->o_instr path.
REQ-012 Handshake o_valid && i_ready SHALL pop the FIFO and advance deliver_pc += 4; o_pc = deliver_pc.
REQ-013 Push and pop in the same cycle SHALL both occur; FIFO SHALL never overflow (guaranteed by REQ-007).
REQ-014 On i_redirect: fetch_pc and deliver_pc <= {i_redirect_pc[31:2],2'b00}; FIFO flushed; drop_cnt <= inflight minus 1 if i_imem_rsp_valid that cycle (else inflight) plus any existing drop_cnt adjustment; no request issued and no handshake counted that cycle.
REQ-015 A response arriving in the redirect cycle SHALL be discarded.
REQ-016 Redirect while drop_cnt > 0 SHALL accumulate: new drop_cnt covers every outstanding request.
REQ-017 Back-to-back redirects SHALL each take effect; the last one defines fetch_pc.
REQ-018 While i_imem_req_ready = 0, state SHALL hold; no address advance.

Reset
REQ-019 While i_rst = 1: fetch_pc = deliver_pc = RESET_PC, inflight = drop_cnt = 0, FIFO empty, o_imem_req_valid = 0, o_valid = 0, o_instr = NOP, o_pc = RESET_PC.
REQ-020 Reset mid-operation SHALL abandon all in-flight requests; i_imem_rsp_valid during i_rst is ignored; instruction memory SHALL share i_rst.
REQ-021 First request SHALL issue in the first cycle after i_rst deasserts, address RESET_PC.

Structure
REQ-022 NOP encoding (32'h0000_0013) and XLEN=32 SHALL live in the shared core defines include, also used by decoder.
REQ-023 FIFO SHALL be a sub-module fetch_fifo (DEPTH, width 32, push/pop/flush, count output).
REQ-024 Output pair o_instr/o_pc SHALL drive decoder i_instr/i_pc directly.

Verification
REQ-025 Reset, RESET_PC=0, ready=1, 1-cycle mem latency, i_ready=1 -> o_pc 0,4,8,... one per cycle from cycle 2 after release, o_instr = mem[pc>>2].
REQ-026 i_ready=0 for 10 cycles -> exactly DEPTH=2 requests issued, o_valid held with o_pc=0; release -> 0,4,8 in order, none lost.
REQ-027 Two requests (0x8,0xC) in flight, redirect to 0x100 -> both responses dropped, next request addr 0x100 the following cycle, next delivered o_pc = 0x100.
REQ-028 Redirect in same cycle as i_imem_rsp_valid and o_valid&&i_ready -> response discarded, no pop counted, deliver_pc = target.
REQ-029 i_imem_req_ready=0 for 5 cycles with addr 0x8 -> addr stays 0x8, valid stays 1, inflight unchanged.
REQ-030 i_rst asserted with 2 in flight and 1 buffered -> next cycle all outputs at reset values; late rsp_valid during reset ignored; first post-reset o_pc = RESET_PC.
